arith_result_fifo: RTL
======================

Name: arith_result_fifo

Overview:
- Registered result buffer directly downstream of the 4-bit arithmetic unit (operands x/y, cin, select s[1:0]; results d, cout).
- Captures each presented result with its carry, op select, cin and a derived zero flag into a first-word-fall-through FIFO.
- Drains the FIFO to a consumer over a valid/ready handshake.
- Counts upstream stall cycles; because the arithmetic unit is combinational, this buffer provides the pipeline's only back-pressure point.

Parameters:
- WIDTH, 4, result width; matches the arithmetic unit's d.
- DEPTH, 4, number of entries; power of two, at least 2.
- CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  FIFO can accept this cycle.
- in_d  in  WIDTH  result d from the arithmetic unit.
- in_cout  in  1  carry-out from the arithmetic unit.
- in_s  in  2  op select used to produce the result.
- in_cin  in  1  carry-in used to produce the result.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_d  out  WIDTH  head result.
- out_cout  out  1  head carry.
- out_s  out  2  head op select.
- out_cin  out  1  head carry-in.
- out_zero  out  1  head result equals 0.
- count  out  $clog2(DEPTH)+1  current occupancy.
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid=1 and in_ready=0.

Behaviour:
- Reset (rst_n=0, asynchronous, at any time including mid-transfer):
  - Outputs: count=0, out_valid=0, in_ready=1, stall_cnt=0; out_d, out_cout, out_s, out_cin and out_zero all 0.
  - Internal state: read and write pointers = 0; stored entries are don't-care.
- Entry format: {in_s, in_cin, in_cout, zero, in_d}, where zero = (in_d == 0).
  - The zero flag is computed at push and stored with the entry, not recomputed at the head.
- in_ready = (count != DEPTH). It is combinational from state only; it never depends on out_ready, so there is no full-state pass-through.
- Push: when in_valid & in_ready, write the entry at wr_ptr; wr_ptr increments modulo DEPTH.
- out_valid = (count != 0). The head entry drives the out_* ports combinationally from storage (first-word fall-through).
  - When out_valid=0, out_d, out_cout, out_s, out_cin and out_zero read 0.
- Pop: when out_valid & out_ready, rd_ptr increments modulo DEPTH.
- Latency: an entry pushed in cycle N is visible at out_* in cycle N+1 when the FIFO was empty.
- count update per cycle:
  - push only: count+1.
  - pop only: count-1.
  - both push and pop: count unchanged.
  - neither: count unchanged.
- Full (count=DEPTH): in_ready=0; any in_valid is refused, no entry is written, and stall_cnt increments.
  - If a pop happens in the same cycle, in_ready rises the following cycle.
- Empty (count=0): a push and a pop cannot coincide, because out_valid=0.
- Pointer wrap: pointers wrap at DEPTH-1 -> 0. Full and empty are distinguished by count, not by pointer equality.
- stall_cnt:
  - Increments by 1 on every in_valid & !in_ready cycle.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- flush:
  - Next edge: count=0, both pointers=0, out_valid=0.
  - Overrides any push or pop in the same cycle; the data is discarded.
  - A stall in the same cycle is still counted if in_ready was 0.
- Handshake rules:
  - The upstream must hold in_d, in_cout, in_s and in_cin stable while in_valid=1 and in_ready=0.
  - The consumer may drop out_ready at any time; the head entry is held.

Test Plan:
- Reset then single push: in_d=4'b1100, cout=0, s=00, cin=0 -> next cycle out_valid=1, out_d=1100, out_zero=0, count=1; pop -> count=0, out_valid=0.
- Fill with out_ready=0: push 1100, 1101, 0110, 0111 (s=00, 00, 01, 01) -> count=4, in_ready=0; hold in_valid 3 more cycles -> stall_cnt=3, and the pops afterwards return the entries in order with the correct s and cin.
- Wrap-around: with out_ready=1 and in_valid=1 continuously, run 10 results -> count stays 1 after the first cycle, outputs match input order, and the pointers wrap twice without loss.
- Full with simultaneous pop: count=4, out_ready=1, in_valid=1 -> this cycle in_ready=0, count becomes 3; next cycle the push is accepted and count=3 (push and pop together).
- Zero flag and flush: push in_d=0000, cout=1 (s=01) -> out_zero=1, out_cout=1; push two more, assert flush together with a push -> next cycle count=0, out_valid=0, stall_cnt unchanged.
- Async reset mid-fill: count=2 and stall_cnt=5, drop rst_n between edges -> outputs immediately count=0, out_valid=0, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/arith_result_fifo.sv
// Registered result buffer placed after the 4-bit arithmetic unit.
// Each accepted result is stored with its carry, op select, carry-in and a
// zero flag in a first-word-fall-through FIFO. The FIFO drains over a
// valid/ready handshake. A saturating counter records the upstream stall
// cycles, because this buffer is the only back-pressure point in the pipeline.
module arith_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_d,
    input  logic                     in_cout,
    input  logic [1:0]               in_s,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_d,
    output logic                     out_cout,
    output logic [1:0]               out_s,
    output logic                     out_cin,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

    // One stored result. The zero flag is computed once, at push time.
    typedef struct packed {
        logic [1:0]       s;
        logic             cin;
        logic             cout;
        logic             zero;
        logic [WIDTH-1:0] d;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           in_entry;
    entry_t           head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             push;
    logic             pop;
    logic             stall;

    // Full and empty come from the occupancy count, never from pointer equality.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign stall     = in_valid & ~in_ready;

    assign in_entry = '{s: in_s, cin: in_cin, cout: in_cout,
                        zero: (in_d == '0), d: in_d};

    // Next-state for pointers, occupancy and the stall counter.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;

        if (flush) begin
            // Flush discards everything, including a push or pop this cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Stalls are still counted during a flush; only reset clears the counter.
        if (stall && (stall_q != '1)) stall_d = stall_q + 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Entry storage written on every accepted push.
    // NOTE: storage is not reset; the gated outputs and count keep stale words from being seen.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= in_entry;
    end

    // The head entry drives the outputs directly; they read zero while the FIFO is empty.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_d     = '0;
        out_cout  = 1'b0;
        out_s     = 2'b00;
        out_cin   = 1'b0;
        out_zero  = 1'b0;
        if (out_valid) begin
            out_d    = head.d;
            out_cout = head.cout;
            out_s    = head.s;
            out_cin  = head.cin;
            out_zero = head.zero;
        end
    end

    assign count     = count_q;
    assign stall_cnt = stall_q;

endmodule
